// File: rtl/demux_striping_n_pkg.sv
// Shared constants and lane-index sizing for the byte-striping demultiplexer.
package demux_strp_pkg;

  localparam int MAX_LANES  = 8;
  localparam int DEF_DATA_W = 32;

  // A lane index is always at least one bit wide, even for two lanes.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 2) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/demux_striping_n_if.sv
// Recirculator-to-lane bus of the striping demultiplexer.
// Handshake: no ready; valid_recirculador qualifies the word in that cycle, one word accepted per cycle.
interface demux_striping_n_if
  import demux_strp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = 2
);
  localparam int LANE_IDX_W = lane_idx_w(LANES);

  logic [DATA_W-1:0]       data_recirculador_active;
  logic                    valid_recirculador;
  logic                    align;
  logic [LANES*DATA_W-1:0] data_demux_strp;
  logic [LANES-1:0]        valid_demux_strp;
  logic [LANE_IDX_W-1:0]   lane_ptr;
  logic                    round_done;

  modport master (
    output data_recirculador_active, valid_recirculador, align,
    input  data_demux_strp, valid_demux_strp, lane_ptr, round_done
  );

  modport slave (
    input  data_recirculador_active, valid_recirculador, align,
    output data_demux_strp, valid_demux_strp, lane_ptr, round_done
  );

endinterface

// File: rtl/demux_striping_n_lane_ptr.sv
// Round-robin lane pointer: counts down from LANES-1 to 0 and wraps, with align load.
module strp_lane_ptr
  import demux_strp_pkg::*;
#(
  parameter int LANES = 2,
  parameter int IDX_W = lane_idx_w(LANES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             align_i,
  input  logic             adv_en_i,
  output logic [IDX_W-1:0] target_o,
  output logic [IDX_W-1:0] ptr_o
);

  localparam logic [IDX_W-1:0] TOP_LANE = IDX_W'(LANES - 1);

  logic [IDX_W-1:0] ptr_q, ptr_d, target, dec;

  always_comb begin
    target = align_i ? TOP_LANE : ptr_q;
    // Explicit wrap keeps the encoding within 0..LANES-1 for non-power-of-two counts.
    dec    = (target == '0) ? TOP_LANE : target - IDX_W'(1);
    ptr_d  = adv_en_i ? dec : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= TOP_LANE;
    else         ptr_q <= ptr_d;
  end

  assign target_o = target;
  assign ptr_o    = ptr_q;

endmodule

// File: rtl/demux_striping_n.sv
// Byte-striping demultiplexer: valid words go round-robin to LANES lanes, highest lane first.
// Optional: DEMUX_STRP_HOLD_ON_IDLE_EN keeps the pointer still on idle cycles.
module demux_striping_n
  import demux_strp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = 2
) (
  input  logic               clk_2f,
  input  logic               reset,
  demux_striping_n_if.slave  bus
);

  localparam int IDX_W = lane_idx_w(LANES);

  logic [IDX_W-1:0] target;
  logic [IDX_W-1:0] ptr_q;
  logic             adv_en;
  logic             round_done_q, round_done_d;

`ifdef DEMUX_STRP_HOLD_ON_IDLE_EN
  // Gapped streams stay lane-aligned; align still forces a move.
  assign adv_en = bus.valid_recirculador | bus.align;
`else
  assign adv_en = 1'b1;
`endif

  strp_lane_ptr #(.LANES(LANES), .IDX_W(IDX_W)) u_ptr (
    .clk_i    (clk_2f),
    .rst_ni   (reset),
    .align_i  (bus.align),
    .adv_en_i (adv_en),
    .target_o (target),
    .ptr_o    (ptr_q)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (target == IDX_W'(k)) begin
        valid_d = bus.valid_recirculador;
        if (bus.valid_recirculador) data_d = bus.data_recirculador_active;
      end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign bus.data_demux_strp[k*DATA_W +: DATA_W] = data_q;
    assign bus.valid_demux_strp[k]                 = valid_q;
  end

  assign round_done_d = bus.valid_recirculador && (target == '0);

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) round_done_q <= 1'b0;
    else        round_done_q <= round_done_d;
  end

  assign bus.round_done = round_done_q;
  assign bus.lane_ptr   = ptr_q;

endmodule
